// File: rtl/div_result_bcd.sv
// Converts a finished divider quotient/remainder pair to packed BCD.
// Both operands run through a shared iterative double-dabble, one bit per clock.
module div_result_bcd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      quotient,
  input  logic [WIDTH-1:0]      remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   q_bcd,
  output logic [DIGITS*4-1:0]   r_bcd,
  output logic                  busy
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   q_bin, q_bin_d, r_bin, r_bin_d;
  logic [BCD_W-1:0]   q_acc, q_acc_d, r_acc, r_acc_d;
  logic [BCD_W-1:0]   q_bcd_d, r_bcd_d;
  logic [SR_W-1:0]    q_step, r_step;

  // One double-dabble iteration: nibble-local add-3, then shift {bcd, bin} left.
  function automatic logic [SR_W-1:0] dabble(input logic [BCD_W-1:0] acc,
                                             input logic [WIDTH-1:0] bin);
    logic [BCD_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return SR_W'({adj, bin} << 1);
  endfunction

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_bin_d = q_bin;
    r_bin_d = r_bin;
    q_acc_d = q_acc;
    r_acc_d = r_acc;
    q_bcd_d = q_bcd;
    r_bcd_d = r_bcd;
    q_step  = dabble(q_acc, q_bin);
    r_step  = dabble(r_acc, r_bin);

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d = CONVERT;
          q_bin_d = quotient;
          r_bin_d = remainder;
          q_acc_d = '0;
          r_acc_d = '0;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        q_acc_d = q_step[SR_W-1:WIDTH];
        q_bin_d = q_step[WIDTH-1:0];
        r_acc_d = r_step[SR_W-1:WIDTH];
        r_bin_d = r_step[WIDTH-1:0];
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_d = DONE;
          q_bcd_d = q_step[SR_W-1:WIDTH];
          r_bcd_d = r_step[SR_W-1:WIDTH];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      q_bin <= '0;
      r_bin <= '0;
      q_acc <= '0;
      r_acc <= '0;
      q_bcd <= '0;
      r_bcd <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      q_bin <= q_bin_d;
      r_bin <= r_bin_d;
      q_acc <= q_acc_d;
      r_acc <= r_acc_d;
      q_bcd <= q_bcd_d;
      r_bcd <= r_bcd_d;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONVERT);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: latency, handshakes, backpressure,
// asynchronous abort and a full decimal sweep against hand-derived digits.
module tb_div_result_bcd;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [11:0] last_q = '0;
  logic [11:0] last_r = '0;

  div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .quotient (quotient),
    .remainder(remainder),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q_bcd    (q_bcd),
    .r_bcd    (r_bcd),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Present a pair and return #1 after the accepting edge.
  task automatic start(input logic [7:0] q, input logic [7:0] r);
    @(negedge clock);
    quotient  = q;
    remainder = r;
    in_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      @(negedge clock);
    end
    chk("accept", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles from acceptance to out_valid; returns at the negedge where it is seen.
  task automatic wait_done(input string tag, input logic [11:0] eq, input logic [11:0] er);
    int lat   = 0;
    int nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        chk({tag, "_inrdy_drop"}, in_ready, 0);
        chk({tag, "_q_held"}, q_bcd, last_q);
      end
      if (busy) nbusy++;
      if (out_valid) break;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_busy_cycles"}, nbusy, 8);
    chk({tag, "_q"}, q_bcd, eq);
    chk({tag, "_r"}, r_bcd, er);
    last_q = eq;
    last_r = er;
  endtask

  // Complete the output handshake from a negedge inside DONE.
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_inrdy_back"}, in_ready, 1);
  endtask

  initial begin
    int ov_seen;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quotient  = '0;
    remainder = '0;
    #12;
    chk("rst_q", q_bcd, 0);
    chk("rst_r", r_bcd, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_inrdy", in_ready, 1);

    // Maximum quotient
    start(8'd255, 8'd7);
    wait_done("max", 12'h255, 12'h007);
    release_out("max");

    // Zeros
    start(8'd0, 8'd0);
    wait_done("zero", 12'h000, 12'h000);
    release_out("zero");

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    start(8'd100, 8'd99);
    wait_done("b2b1", 12'h100, 12'h099);
    quotient  = 8'd9;
    remainder = 8'd10;
    in_valid  = 1'b1;
    @(negedge clock);
    chk("b2b_ov_one", out_valid, 0);
    chk("b2b_no_accept", busy, 0);
    chk("b2b_inrdy", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_done("b2b2", 12'h009, 12'h010);
    @(negedge clock);
    chk("b2b2_ov_one", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure with an ignored in_valid during the stall
    start(8'd42, 8'd13);
    wait_done("bp", 12'h042, 12'h013);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        quotient = 8'd1;
        in_valid = 1'b1;
      end
      @(negedge clock);
      chk("bp_ov", out_valid, 1);
      chk("bp_q", q_bcd, 12'h042);
      chk("bp_inrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("bp_r", r_bcd, 12'h013);
    release_out("bp");
    chk("bp_idle", busy, 0);
    chk("bp_q_after", q_bcd, 12'h042);

    // Asynchronous abort at iteration 4
    start(8'd200, 8'd55);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_q", q_bcd, 0);
    chk("abort_r", r_bcd, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    last_q = '0;
    last_r = '0;
    @(negedge clock);
    chk("abort_inrdy", in_ready, 1);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_ov", ov_seen, 0);

    // Full sweep against decimal digits
    for (int v = 0; v < 256; v++) begin
      start(8'(v), 8'(255 - v));
      wait_done("sweep", to_bcd(v), to_bcd(255 - v));
      release_out("sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
